// File: rtl/exc_ctrl.sv
// Exception controller at the MEM/WB boundary. It resolves the highest-priority exception
// and sequences a one-cycle pipeline flush, followed by a short drain window.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_excflags_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  drain_cnt;
  logic [31:0] eff_status, eff_cause, eff_epc;
  logic [31:0] resolved_code;
  logic        int_pending;
  logic        take_exc;
  logic        unused_bits;

  // A CP0 write still sitting in WB must be visible here; only the software IP bits of cause forward
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) eff_status = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) eff_cause[9:8] = wb_cp0_data_i[9:8];
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) eff_epc = wb_cp0_data_i;
  end

  assign int_pending = ((eff_cause[15:8] & eff_status[15:8]) != 8'd0) &&
                       eff_status[0] && !eff_status[1];

  always_comb begin
    resolved_code = 32'd0;
    if (int_pending)            resolved_code = 32'h1;
    else if (mem_excflags_i[8])  resolved_code = 32'h8;
    else if (mem_excflags_i[9])  resolved_code = 32'ha;
    else if (mem_excflags_i[10]) resolved_code = 32'hd;
    else if (mem_excflags_i[11]) resolved_code = 32'hc;
    else if (mem_excflags_i[12]) resolved_code = 32'he;
  end

  always_comb begin
    excepttype_o = 32'd0;
    if (!rst && state == IDLE && mem_valid_i && !stall_i) excepttype_o = resolved_code;
    busy_o = (state != IDLE);
  end

  assign take_exc            = (excepttype_o != 32'd0);
  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_exc) state_next = FLUSH;
      FLUSH:   state_next = DRAIN;
      DRAIN:   if (drain_cnt == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The redirect target is captured on the same edge that detects the exception
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_o   <= 1'b0;
      new_pc_o  <= 32'd0;
      drain_cnt <= 3'd0;
    end else begin
      state   <= state_next;
      flush_o <= (state == IDLE) && take_exc;
      if (state == IDLE && take_exc)
        new_pc_o <= (excepttype_o == 32'he) ? eff_epc : EXC_VECTOR;
      if (state == FLUSH)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != 3'd0)
        drain_cnt <= drain_cnt - 3'd1;
    end
  end

  assign unused_bits = ^{mem_excflags_i[31:13], mem_excflags_i[7:0],
                         eff_cause[31:16], eff_cause[7:0],
                         eff_status[31:16], eff_status[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a cycle-count reference model.
module tb_exc_ctrl;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;
  localparam int          DRAIN_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, mem_valid, delayslot, wb_we;
  logic [31:0] flags, mem_pc, status, cause, epc, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] excepttype, cur_addr, new_pc;
  logic        in_ds, flush, busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: cycles of busy remaining, plus the last redirect
  int          m_busy_left = 0;
  logic        m_flush     = 1'b0;
  logic [31:0] m_new_pc    = 32'd0;

  exc_ctrl #(.EXC_VECTOR(EXC_VECTOR), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .mem_valid_i(mem_valid),
    .mem_excflags_i(flags), .mem_pc_i(mem_pc), .mem_in_delayslot_i(delayslot),
    .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_addr), .wb_cp0_data_i(wb_data),
    .excepttype_o(excepttype), .current_inst_addr_o(cur_addr),
    .is_in_delayslot_o(in_ds), .flush_o(flush), .new_pc_o(new_pc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, stall, ds, we;
    logic [31:0] flags, pc, status, cause, epc, wdata, exp_code, exp_pc;
    logic [4:0]  waddr;
  } vec_t;

  function automatic vec_t mkv(string name, logic valid, logic stl, logic ds,
                               logic [31:0] fl, logic [31:0] pc, logic [31:0] st,
                               logic [31:0] ca, logic [31:0] ep, logic we,
                               logic [4:0] wa, logic [31:0] wd,
                               logic [31:0] ec, logic [31:0] epc_exp);
    vec_t v;
    v.name = name; v.valid = valid; v.stall = stl; v.ds = ds; v.flags = fl;
    v.pc = pc; v.status = st; v.cause = ca; v.epc = ep; v.we = we;
    v.waddr = wa; v.wdata = wd; v.exp_code = ec; v.exp_pc = epc_exp;
    return v;
  endfunction

  // Codes listed in priority order, which happens to match flag bit order 8..12
  function automatic logic [31:0] ref_code();
    logic [31:0] codes [5];
    logic [31:0] st, ca;
    codes = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he};
    st = (wb_we && wb_addr == 5'd12) ? wb_data : status;
    ca = cause;
    if (wb_we && wb_addr == 5'd13) ca[9:8] = wb_data[9:8];
    if (rst || m_busy_left != 0 || !mem_valid || stall) return 32'd0;
    if ((ca[15:8] & st[15:8]) != 8'd0 && st[0] == 1'b1 && st[1] == 1'b0) return 32'h1;
    for (int b = 8; b <= 12; b++)
      if (flags[b]) return codes[b - 8];
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_epc();
    return (wb_we && wb_addr == 5'd14) ? wb_data : epc;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; checks, clocks, advances the model
  task automatic apply_stimulus();
    logic [31:0] exp_code;
    #1;
    exp_code = ref_code();
    check("excepttype", excepttype, exp_code);
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("busy", {31'd0, busy}, {31'd0, m_busy_left != 0});
    check("new_pc", new_pc, m_new_pc);
    check("inst_addr", cur_addr, mem_pc);
    check("delayslot", {31'd0, in_ds}, {31'd0, delayslot});
    @(posedge clk);
    if (rst) begin
      m_busy_left = 0; m_flush = 1'b0; m_new_pc = 32'd0;
    end else if (m_busy_left > 0) begin
      m_busy_left--; m_flush = 1'b0;
    end else if (exp_code != 32'd0) begin
      m_busy_left = 1 + DRAIN_CYCLES;
      m_flush     = 1'b1;
      m_new_pc    = (exp_code == 32'he) ? ref_epc() : EXC_VECTOR;
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    mem_valid = 1'b0; stall = 1'b0; wb_we = 1'b0; flags = 32'd0;
    repeat (n) apply_stimulus();
  endtask

  task automatic drive_syscall(logic [31:0] pc);
    mem_valid = 1'b1; stall = 1'b0; flags = 32'h100; mem_pc = pc;
    status = 32'd0; cause = 32'd0; wb_we = 1'b0;
  endtask

  vec_t vecs [15];
  int   busy_cycles;

  initial begin
    vecs[0]  = mkv("syscall",      1, 0, 0, 32'h0000_0100, 32'h80001000, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'h8, EXC_VECTOR);
    vecs[1]  = mkv("irq_wins",     1, 0, 0, 32'h0000_0900, 32'h80001004, 32'h0000FF01, 32'h400, 32'h0,    0, 5'd0,  32'h0,        32'h1, EXC_VECTOR);
    vecs[2]  = mkv("eret_fwd_epc", 1, 0, 0, 32'h0000_1000, 32'h80001008, 32'h2,      32'h0,   32'h80000010, 1, 5'd14, 32'h80000200, 32'he, 32'h80000200);
    vecs[3]  = mkv("ds_syscall",   1, 0, 1, 32'h0000_0100, 32'h80000104, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'h8, EXC_VECTOR);
    vecs[4]  = mkv("ri",           1, 0, 0, 32'h0000_1E00, 32'h80002000, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'ha, EXC_VECTOR);
    vecs[5]  = mkv("trap",         1, 0, 0, 32'h0000_0C00, 32'h80002004, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'hd, EXC_VECTOR);
    vecs[6]  = mkv("overflow",     1, 0, 0, 32'h0000_1800, 32'h80002008, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'hc, EXC_VECTOR);
    vecs[7]  = mkv("eret_exl0",    1, 0, 0, 32'h0000_1000, 32'h8000200C, 32'h0,      32'h0,   32'h80000010, 0, 5'd0, 32'h0,       32'he, 32'h80000010);
    vecs[8]  = mkv("irq_exl_mask", 1, 0, 0, 32'h0,         32'h80003000, 32'h0000FF03, 32'h400, 32'h0,    0, 5'd0,  32'h0,        32'h0, 32'h0);
    vecs[9]  = mkv("irq_fwd_cause",1, 0, 0, 32'h0,         32'h80003004, 32'h101,    32'h0,   32'h0,      1, 5'd13, 32'h100,      32'h1, EXC_VECTOR);
    vecs[10] = mkv("cause_hw_nofwd",1,0, 0, 32'h0,         32'h80003008, 32'h0000FF01, 32'h0, 32'h0,      1, 5'd13, 32'h400,      32'h0, 32'h0);
    vecs[11] = mkv("irq_fwd_status",1,0, 0, 32'h0,         32'h8000300C, 32'h0,      32'h400, 32'h0,      1, 5'd12, 32'h401,      32'h1, EXC_VECTOR);
    vecs[12] = mkv("bubble",       0, 0, 0, 32'h0000_0100, 32'h80004000, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'h0, 32'h0);
    vecs[13] = mkv("ignored_bits", 1, 0, 0, 32'hFFFF_E0FF, 32'h80004004, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'h0, 32'h0);
    vecs[14] = mkv("stalled",      1, 1, 0, 32'h0000_0100, 32'h80004008, 32'h0,      32'h0,   32'h0,      0, 5'd0,  32'h0,        32'h0, 32'h0);

    rst = 1'b1; stall = 1'b0; mem_valid = 1'b0; delayslot = 1'b0; wb_we = 1'b0;
    flags = 32'd0; mem_pc = 32'd0; status = 32'd0; cause = 32'd0; epc = 32'd0;
    wb_addr = 5'd0; wb_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset holds excepttype low even with a live syscall in MEM
    drive_syscall(32'h80000500);
    apply_stimulus();
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 15; i++) begin
      mem_valid = vecs[i].valid; stall = vecs[i].stall; delayslot = vecs[i].ds;
      flags = vecs[i].flags; mem_pc = vecs[i].pc; status = vecs[i].status;
      cause = vecs[i].cause; epc = vecs[i].epc; wb_we = vecs[i].we;
      wb_addr = vecs[i].waddr; wb_data = vecs[i].wdata;
      #1;
      check({vecs[i].name, "_code"}, excepttype, vecs[i].exp_code);
      apply_stimulus();
      if (vecs[i].exp_code != 32'd0) begin
        check({vecs[i].name, "_flush"}, {31'd0, flush}, 32'd1);
        check({vecs[i].name, "_new_pc"}, new_pc, vecs[i].exp_pc);
      end
      delayslot = 1'b0;
      idle(1 + DRAIN_CYCLES);
    end

    // Busy spans the flush cycle plus the full drain window
    drive_syscall(32'h80001000);
    apply_stimulus();
    mem_valid = 1'b0; flags = 32'd0;
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cycles++;
      apply_stimulus();
    end
    check("busy_len", busy_cycles, 1 + DRAIN_CYCLES);

    // An exception held through the drain is reported once the controller is idle again
    drive_syscall(32'h80005000);
    apply_stimulus();
    drive_syscall(32'h80005004);
    for (int i = 0; i < 10 && busy; i++) apply_stimulus();
    check("drain_exit", {31'd0, busy}, 32'd0);
    #1;
    check("held_reported", excepttype, 32'h8);
    apply_stimulus();
    check("held_flush", {31'd0, flush}, 32'd1);
    idle(1 + DRAIN_CYCLES);

    // Stall masks the exception until the instruction can commit
    drive_syscall(32'h80006000);
    stall = 1'b1;
    apply_stimulus();
    check("stall_no_flush", {31'd0, flush}, 32'd0);
    stall = 1'b0;
    #1;
    check("unstall_code", excepttype, 32'h8);
    apply_stimulus();
    idle(1 + DRAIN_CYCLES);

    // Reset during the flush cycle aborts straight to idle
    drive_syscall(32'h80007000);
    apply_stimulus();
    check("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1; mem_valid = 1'b0;
    apply_stimulus();
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_new_pc", new_pc, 32'd0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      mem_valid = ($urandom_range(0, 3) != 0);
      delayslot = $urandom_range(0, 1) == 1;
      flags     = $urandom;
      if ($urandom_range(0, 1) == 1) flags[12:8] = 5'd0;
      mem_pc    = $urandom;
      status    = $urandom;
      cause     = $urandom;
      epc       = $urandom;
      wb_we     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom_range(11, 15));
      wb_data   = $urandom;
      apply_stimulus();
    end
    rst = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
- REQ-001: Parameter EXC_VECTOR, default 32'hBFC00380, general exception/interrupt entry address.
- REQ-002: Parameter DRAIN_CYCLES, default 2, post-flush cycles during which new exceptions are suppressed (range 1..7).
- REQ-003: clk  in  1  single clock; all state updates on its rising edge.
- REQ-004: rst  in  1  synchronous, active-high reset.
- REQ-005: stall_i  in  1  MEM stage stalled; held instruction not yet committable.
- REQ-006: mem_valid_i  in  1  MEM stage holds a real instruction (not a bubble).
- REQ-007: mem_excflags_i  in  32  raw flags: bit8 syscall, bit9 reserved-instr, bit10 trap, bit11 overflow, bit12 eret; other bits ignored.
- REQ-008: mem_pc_i  in  32  PC of MEM instruction.
- REQ-009: mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- REQ-010: cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
- REQ-011: wb_cp0_we_i  in  1, wb_cp0_waddr_i  in  5, wb_cp0_data_i  in  32  CP0 write in flight from WB.
- REQ-012: excepttype_o  out  32  resolved code to CP0: 0 none, 1 interrupt, 8 syscall, 'ha RI, 'hc overflow, 'hd trap, 'he eret.
- REQ-013: current_inst_addr_o  out  32  faulting PC to CP0.
- REQ-014: is_in_delayslot_o  out  1  delay-slot flag to CP0.
- REQ-015: flush_o  out  1  registered one-cycle pipeline flush.
- REQ-016: new_pc_o  out  32  registered redirect target, valid while flush_o=1.
- REQ-017: busy_o  out  1  high in FLUSH or DRAIN.

Function
- REQ-018: Effective status/cause/epc = wb_cp0_data_i when wb_cp0_we_i=1 and wb_cp0_waddr_i equals 12/13/14 respectively, else the cp0_*_i value; for cause, only bits [9:8] forward, other bits from cp0_cause_i.
- REQ-019: Interrupt pending = (eff_cause[15:8] & eff_status[15:8]) != 0 and eff_status[0]=1 and eff_status[1]=0.
- REQ-020: Resolution is combinational, priority: interrupt(1) > syscall(8) > RI('ha) > trap('hd) > overflow('hc) > eret('he); first match wins.
- REQ-021: excepttype_o = resolved code only when state=IDLE, mem_valid_i=1, stall_i=0; otherwise 0.
- REQ-022: current_inst_addr_o = mem_pc_i and is_in_delayslot_o = mem_in_delayslot_i at all times (CP0 gates on excepttype_o).
- REQ-023: FSM states IDLE, FLUSH, DRAIN.
- REQ-024: IDLE -> FLUSH when excepttype_o != 0; next cycle flush_o=1 and new_pc_o = eff_epc (for 'he) or EXC_VECTOR (others), both captured at the detecting edge.
- REQ-025: FLUSH -> DRAIN unconditionally after one cycle; flush_o deasserts, counter loads DRAIN_CYCLES-1.
- REQ-026: DRAIN decrements counter each cycle; DRAIN -> IDLE when counter = 0 (DRAIN lasts exactly DRAIN_CYCLES cycles).
- REQ-027: stall_i has no effect on FLUSH/DRAIN progression.
- REQ-028: new_pc_o holds its last value outside FLUSH.
- REQ-029: Eret with eff_status[1]=0 is still reported as 'he (CP0 decides).

Reset
- REQ-030: On rst=1 at a clock edge: state=IDLE, flush_o=0, new_pc_o=0, counter=0, busy_o=0; reset mid-FLUSH/DRAIN aborts to IDLE next cycle.
- REQ-031: While rst=1, excepttype_o=0 regardless of inputs.

Verification
- REQ-032: mem_valid=1, flags bit8, pc=32'h80001000, status=0 -> excepttype_o=8 same cycle; next cycle flush_o=1, new_pc_o=32'hBFC00380; busy_o high 1+DRAIN_CYCLES cycles.
- REQ-033: flags bit8|bit11, status=32'h0000FF01, cause[10]=1 -> excepttype_o=1 (interrupt wins).
- REQ-034: flags bit12, cp0_epc=32'h80000010, wb writes EPC=32'h80000200 same cycle -> flush next cycle with new_pc_o=32'h80000200.
- REQ-035: Exception flagged during DRAIN or with stall_i=1 -> excepttype_o=0, no flush; same instruction reported once state=IDLE and stall_i=0.
- REQ-036: rst asserted in the FLUSH cycle -> flush_o=0, busy_o=0 next cycle; state IDLE.
- REQ-037: Delay-slot syscall at pc=32'h80000104 -> is_in_delayslot_o=1, current_inst_addr_o=32'h80000104 with excepttype_o=8.
